// File: rtl/call_queue.sv
// Hall-call front end: synchronises and debounces three floor buttons and keeps
// pending calls in arrival order so the movement stage always sees the oldest one.
module call_queue #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       btn3,
    input  logic       floor1,
    input  logic       floor2,
    input  logic       floor3,
    input  logic       door,
    input  logic       moving,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] target,
    output logic       pending
);

    // Counter value on the edge where the DEBOUNCE-th stable cycle completes.
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);

    logic [2:0] btn, flr;
    logic [2:0] meta, sync, deb, deb_q;
    logic [3:0] cnt [3];
    logic [2:0] press, svc, led, led_next;
    logic       multi, rm;
    logic [1:0] q [3];
    logic [1:0] q_next [3];
    logic [1:0] count, count_next, target_next;

    assign btn = {btn3, btn2, btn1};
    assign flr = {floor3, floor2, floor1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= '0;
            sync  <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            deb_q <= deb;
            for (int k = 0; k < 3; k++) begin
                if (sync[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == DEB_LAST) begin
                    deb[k] <= sync[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 4'd1;
                end
            end
        end
    end

    // Only a debounced rising level is a press; releases are silent.
    assign press = deb & ~deb_q;

    // An ambiguous floor indication must never retire a call.
    assign multi = (flr[0] & flr[1]) | (flr[0] & flr[2]) | (flr[1] & flr[2]);
    assign svc   = (door && !moving && !multi) ? flr : 3'b000;

    always_comb begin
        q_next     = '{default: 2'd0};
        count_next = 2'd0;
        rm         = 1'b0;
        // Compact surviving entries toward the head, then append new calls.
        for (int i = 0; i < 3; i++) begin
            rm = (q[i] == 2'd1 && svc[0]) || (q[i] == 2'd2 && svc[1]) ||
                 (q[i] == 2'd3 && svc[2]);
            if (i < int'(count) && !rm) begin
                q_next[count_next] = q[i];
                count_next         = count_next + 2'd1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (press[k] && !led[k] && !svc[k] && count_next != 2'd3) begin
                q_next[count_next] = 2'(k + 1);
                count_next         = count_next + 2'd1;
            end
        end
        led_next    = (led | press) & ~svc;
        target_next = (count_next != 2'd0) ? q_next[0] : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) q[i] <= 2'd0;
            count   <= 2'd0;
            led     <= 3'b000;
            target  <= 2'd0;
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) q[i] <= q_next[i];
            count   <= count_next;
            led     <= led_next;
            target  <= target_next;
            pending <= |led_next;
        end
    end

    assign led1 = led[0];
    assign led2 = led[1];
    assign led3 = led[2];

endmodule
